// File: rtl/tcm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tcm_pkg
// Purpose : Shared types and helpers for the banked TCM: FSM state encoding,
//           byte-lane mask generation, byte merge and read latency.
// Rev     : 1.0  initial release
// ============================================================================
package tcm_pkg;

  // Fill sequencer states; ST_RUN is terminal until the next reset.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } tcm_state_t;

  // Read latency in cycles seen by both ports.
  function automatic int tcm_latency(input int out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

  // 32-bit strobes land on the half of the 64-bit word picked by addr[2].
  function automatic logic [7:0] lane_mask(input logic hi, input logic [3:0] strb);
    return hi ? {strb, 4'b0000} : {4'b0000, strb};
  endfunction

  // Replace the masked bytes of 'old_w' with the same bytes of 'new_w'.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                             input logic [7:0]  mask,
                                             input logic [63:0] new_w);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcm_mem_banked_if.sv
`default_nettype none
// ============================================================================
// Module  : tcm_mem_banked_if
// Purpose : Fetch and data bus bundle between the core (master) and the TCM
//           (slave).
// Rev     : 1.0  initial release
// ============================================================================
interface tcm_mem_banked_if #(
  parameter int TAG_W = 11
);
  // Fetch port
  logic              mem_i_rd_i;
  logic              mem_i_flush_i;
  logic              mem_i_invalidate_i;
  logic [31:0]       mem_i_pc_i;
  logic              mem_i_accept_o;
  logic              mem_i_valid_o;
  logic              mem_i_error_o;
  logic [63:0]       mem_i_inst_o;
  // Data port
  logic [31:0]       mem_d_addr_i;
  logic [31:0]       mem_d_data_wr_i;
  logic              mem_d_rd_i;
  logic [3:0]        mem_d_wr_i;
  logic              mem_d_cacheable_i;
  logic [TAG_W-1:0]  mem_d_req_tag_i;
  logic              mem_d_invalidate_i;
  logic              mem_d_writeback_i;
  logic              mem_d_flush_i;
  logic [31:0]       mem_d_data_rd_o;
  logic              mem_d_accept_o;
  logic              mem_d_ack_o;
  logic              mem_d_error_o;
  logic [TAG_W-1:0]  mem_d_resp_tag_o;

  modport master (
    output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
    output mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
    output mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
    input  mem_d_resp_tag_o
  );

  modport slave (
    input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
    input  mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
    input  mem_d_writeback_i, mem_d_flush_i,
    output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o,
    output mem_d_resp_tag_o
  );
endinterface
`default_nettype wire

// File: rtl/tcm_mem_ram.sv
`default_nettype none
// ============================================================================
// Module  : tcm_mem_ram
// Purpose : Generic dual-port SRAM, 2^ADDR_W x 64. Port 0 is read-only,
//           port 1 reads and writes with a byte mask. 1-cycle read,
//           read-before-write on a same-cycle address match.
// Rev     : 1.0  initial release
// ============================================================================
module tcm_mem_ram #(
  parameter int ADDR_W = 5
) (
  input  wire logic              clk_i,
  input  wire logic [ADDR_W-1:0] i_addr0,
  output      logic [63:0]       o_rdata0,
  input  wire logic [ADDR_W-1:0] i_addr1,
  input  wire logic [7:0]        i_wmask1,
  input  wire logic [63:0]       i_wdata1,
  output      logic [63:0]       o_rdata1
);

  logic [63:0] mem [0:(2**ADDR_W)-1];
  logic [63:0] r_rdata0;
  logic [63:0] r_rdata1;

  // Synchronous reads on both ports plus byte-masked write on port 1.
  always_ff @(posedge clk_i) begin
    r_rdata0 <= mem[i_addr0];
    r_rdata1 <= mem[i_addr1];
    for (int b = 0; b < 8; b++) begin
      if (i_wmask1[b]) mem[i_addr1][b*8 +: 8] <= i_wdata1[b*8 +: 8];
    end
  end

  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: rtl/tcm_mem_banked.sv
`default_nettype none
// ============================================================================
// Module  : tcm_mem_banked
// Purpose : Dual-port TCM: 64-bit fetch port and 32-bit tagged data port with
//           range checking, write-to-fetch forwarding and post-reset
//           zero-fill.
// Rev     : 1.0  initial release
// ============================================================================
module tcm_mem_banked
  import tcm_pkg::*;
#(
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          OUT_REG   = 1,
  parameter int          INIT_ZERO = 1,
  parameter int          TAG_W     = 11
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  tcm_mem_banked_if.slave  bus,
  output      logic        init_done_o
);

  localparam int              LAT        = tcm_latency(OUT_REG);
  localparam logic [ADDR_W-1:0] C_LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] C_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  tcm_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              w_run;

  // Fetch request decode
  logic              w_i_fire, w_i_inrange;
  logic [ADDR_W-1:0] w_i_idx;
  // Data request decode
  logic              w_d_is_wr, w_d_fire, w_d_inrange, w_d_we, w_d_err;
  logic [ADDR_W-1:0] w_d_idx;
  logic [7:0]        w_d_mask;
  logic [63:0]       w_d_wdata;
  logic              w_col;
  // RAM port 1 mux (fill sequencer vs data port)
  logic [ADDR_W-1:0] w_p1_addr;
  logic [7:0]        w_p1_mask;
  logic [63:0]       w_p1_data;
  logic [63:0]       w_q0, w_q1;
  // Stage 1 (RAM output) registers
  logic              r_i_v1, r_i_err1, r_col1;
  logic [7:0]        r_col_mask1;
  logic [63:0]       r_col_data1;
  logic              r_d_v1, r_d_err1, r_d_rd1, r_d_hi1;
  logic [TAG_W-1:0]  r_d_tag1;
  logic [63:0]       w_inst1;
  logic [31:0]       w_drd1;
  logic              w_unused;

  assign w_run       = (r_state == ST_RUN);
  assign init_done_o = w_run;
  assign bus.mem_i_accept_o = w_run;
  assign bus.mem_d_accept_o = w_run;

  // Cache-maintenance hints and sub-word address bits carry no meaning here.
  assign w_unused = ^{bus.mem_i_flush_i, bus.mem_i_invalidate_i, bus.mem_d_cacheable_i,
                      bus.mem_i_pc_i[2:0], bus.mem_d_addr_i[1:0]};

  // Fill sequencer state and word counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + C_ONE;
    end
  end

  // Leave ST_INIT once the last word has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == C_LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Request decode for both ports.
  always_comb begin
    w_i_fire    = bus.mem_i_rd_i & w_run;
    w_i_idx     = bus.mem_i_pc_i[ADDR_W+2:3];
    w_i_inrange = (bus.mem_i_pc_i[31:ADDR_W+3] == BASE_ADDR[31:ADDR_W+3]);
    w_d_is_wr   = |bus.mem_d_wr_i;
    w_d_fire    = w_run & (bus.mem_d_rd_i | w_d_is_wr | bus.mem_d_flush_i |
                           bus.mem_d_invalidate_i | bus.mem_d_writeback_i);
    w_d_idx     = bus.mem_d_addr_i[ADDR_W+2:3];
    w_d_inrange = (bus.mem_d_addr_i[31:ADDR_W+3] == BASE_ADDR[31:ADDR_W+3]);
    w_d_mask    = lane_mask(bus.mem_d_addr_i[2], bus.mem_d_wr_i);
    w_d_wdata   = {bus.mem_d_data_wr_i, bus.mem_d_data_wr_i};
    w_d_we      = w_d_fire & w_d_is_wr & w_d_inrange;
    // Only real accesses can be out of range; cache ops just get acked.
    w_d_err     = w_d_fire & (bus.mem_d_rd_i | w_d_is_wr) & ~w_d_inrange;
    w_col       = w_i_fire & w_i_inrange & w_d_we & (w_i_idx == w_d_idx);
  end

  // Port 1 belongs to the zero-fill sequencer until init completes.
  always_comb begin
    w_p1_addr = w_d_idx;
    w_p1_mask = w_d_we ? w_d_mask : 8'h00;
    w_p1_data = w_d_wdata;
    if (!w_run) begin
      w_p1_addr = r_init_cnt;
      w_p1_mask = 8'hFF;
      w_p1_data = 64'h0;
    end
  end

  tcm_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i    (clk_i),
    .i_addr0  (w_i_idx),
    .o_rdata0 (w_q0),
    .i_addr1  (w_p1_addr),
    .i_wmask1 (w_p1_mask),
    .i_wdata1 (w_p1_data),
    .o_rdata1 (w_q1)
  );

  // Request attributes travelling alongside the RAM read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_i_v1      <= 1'b0;
      r_i_err1    <= 1'b0;
      r_col1      <= 1'b0;
      r_col_mask1 <= 8'h00;
      r_col_data1 <= 64'h0;
      r_d_v1      <= 1'b0;
      r_d_err1    <= 1'b0;
      r_d_rd1     <= 1'b0;
      r_d_hi1     <= 1'b0;
      r_d_tag1    <= '0;
    end else begin
      r_i_v1      <= w_i_fire;
      r_i_err1    <= w_i_fire & ~w_i_inrange;
      r_col1      <= w_col;
      r_col_mask1 <= w_col ? w_d_mask : 8'h00;
      r_col_data1 <= w_d_wdata;
      r_d_v1      <= w_d_fire;
      r_d_err1    <= w_d_err;
      r_d_rd1     <= w_d_fire & bus.mem_d_rd_i & ~w_d_is_wr & w_d_inrange;
      r_d_hi1     <= bus.mem_d_addr_i[2];
      r_d_tag1    <= w_d_fire ? bus.mem_d_req_tag_i : '0;
    end
  end

  // Stage-1 response data; the SRAM read missed a same-cycle write, so patch it.
  always_comb begin
    w_inst1 = 64'h0;
    if (r_i_v1 && !r_i_err1) w_inst1 = r_col1 ? byte_merge(w_q0, r_col_mask1, r_col_data1) : w_q0;
    w_drd1 = 32'h0;
    if (r_d_rd1) w_drd1 = r_d_hi1 ? w_q1[63:32] : w_q1[31:0];
  end

  generate
    if (LAT == 2) begin : g_out_reg
      logic             r_i_v2, r_i_err2, r_d_v2, r_d_err2;
      logic [63:0]      r_inst2;
      logic [31:0]      r_drd2;
      logic [TAG_W-1:0] r_tag2;

      // Extra output register stage for timing.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_i_v2   <= 1'b0;
          r_i_err2 <= 1'b0;
          r_inst2  <= 64'h0;
          r_d_v2   <= 1'b0;
          r_d_err2 <= 1'b0;
          r_drd2   <= 32'h0;
          r_tag2   <= '0;
        end else begin
          r_i_v2   <= r_i_v1;
          r_i_err2 <= r_i_err1;
          r_inst2  <= w_inst1;
          r_d_v2   <= r_d_v1;
          r_d_err2 <= r_d_err1;
          r_drd2   <= w_drd1;
          r_tag2   <= r_d_tag1;
        end
      end

      assign bus.mem_i_valid_o    = r_i_v2;
      assign bus.mem_i_error_o    = r_i_err2;
      assign bus.mem_i_inst_o     = r_inst2;
      assign bus.mem_d_ack_o      = r_d_v2;
      assign bus.mem_d_error_o    = r_d_err2;
      assign bus.mem_d_data_rd_o  = r_drd2;
      assign bus.mem_d_resp_tag_o = r_tag2;
    end else begin : g_no_out_reg
      assign bus.mem_i_valid_o    = r_i_v1;
      assign bus.mem_i_error_o    = r_i_err1;
      assign bus.mem_i_inst_o     = w_inst1;
      assign bus.mem_d_ack_o      = r_d_v1;
      assign bus.mem_d_error_o    = r_d_err1;
      assign bus.mem_d_data_rd_o  = w_drd1;
      assign bus.mem_d_resp_tag_o = r_d_tag1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tcm_mem_banked.sv
`default_nettype none
// ============================================================================
// Module  : tb_tcm_mem_banked
// Purpose : Scoreboard testbench for tcm_mem_banked (ADDR_W=5, OUT_REG=1).
// Rev     : 1.0  initial release
// ============================================================================
module tb_tcm_mem_banked;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [10:0] tag;
    int          due;
  } d_exp_t;

  typedef struct {
    logic [63:0] inst;
    logic        err;
    int          due;
  } f_exp_t;

  d_exp_t d_q[$];
  f_exp_t f_q[$];
  d_exp_t mon_d;
  f_exp_t mon_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcm_mem_banked_if #(.TAG_W(11)) bus ();

  tcm_mem_banked #(
    .ADDR_W(5), .BASE_ADDR(32'h0000_0000), .OUT_REG(1), .INIT_ZERO(1), .TAG_W(11)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus         (bus),
    .init_done_o (init_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.mem_i_rd_i = 0;         bus.mem_i_flush_i = 0;   bus.mem_i_invalidate_i = 0;
    bus.mem_i_pc_i = 0;         bus.mem_d_addr_i = 0;    bus.mem_d_data_wr_i = 0;
    bus.mem_d_rd_i = 0;         bus.mem_d_wr_i = 0;      bus.mem_d_cacheable_i = 0;
    bus.mem_d_req_tag_i = 0;    bus.mem_d_invalidate_i = 0;
    bus.mem_d_writeback_i = 0;  bus.mem_d_flush_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic set_data(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                          input logic [3:0] wr, input logic [10:0] tag,
                          input logic [31:0] exp_data, input logic exp_err);
    d_exp_t e;
    bus.mem_d_addr_i = addr;  bus.mem_d_data_wr_i = wdata;
    bus.mem_d_rd_i = rd;      bus.mem_d_wr_i = wr;  bus.mem_d_req_tag_i = tag;
    e.data = exp_data;  e.err = exp_err;  e.tag = tag;  e.due = cyc + L;
    d_q.push_back(e);
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic [63:0] exp_inst, input logic exp_err);
    f_exp_t e;
    bus.mem_i_rd_i = 1'b1;  bus.mem_i_pc_i = pc;
    e.inst = exp_inst;  e.err = exp_err;  e.due = cyc + L;
    f_q.push_back(e);
  endtask

  task automatic wait_init(input int drop_until, output int n, output logic bad);
    n = 0;
    bad = 1'b0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == drop_until) clear_in();
      if (!init_done && (bus.mem_i_accept_o || bus.mem_d_accept_o)) bad = 1'b1;
    end while (!init_done && n < 100);
  endtask

  task automatic drain();
    int n = 0;
    while ((d_q.size() != 0 || f_q.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (d_q.size() != 0 || f_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d data / %0d fetch responses outstanding, expected 0",
               d_q.size(), f_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every response against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_d_ack_o) begin
        if (d_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_unexpected: ack with tag 0x%0h, expected no ack", bus.mem_d_resp_tag_o);
        end else begin
          mon_d = d_q.pop_front();
          chk("d_data", 64'(bus.mem_d_data_rd_o), 64'(mon_d.data));
          chk("d_err", 64'(bus.mem_d_error_o), 64'(mon_d.err));
          chk("d_tag", 64'(bus.mem_d_resp_tag_o), 64'(mon_d.tag));
          chk("d_latency_cycle", 64'(cyc), 64'(mon_d.due));
        end
      end
      if (bus.mem_i_valid_o) begin
        if (f_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL f_unexpected: valid with inst 0x%0h, expected no valid", bus.mem_i_inst_o);
        end else begin
          mon_f = f_q.pop_front();
          chk("f_inst", bus.mem_i_inst_o, mon_f.inst);
          chk("f_err", 64'(bus.mem_i_error_o), 64'(mon_f.err));
          chk("f_latency_cycle", 64'(cyc), 64'(mon_f.due));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic bad;
    clear_in();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_accept", 64'(bus.mem_i_accept_o), 64'd0);
    chk("rst_d_accept", 64'(bus.mem_d_accept_o), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_outputs", 64'({bus.mem_d_ack_o, bus.mem_i_valid_o, bus.mem_d_error_o, bus.mem_i_error_o}), 64'd0);

    // Requests presented during the fill must be dropped (write would corrupt 0x18).
    bus.mem_i_rd_i = 1'b1;  bus.mem_i_pc_i = 32'h0;
    bus.mem_d_addr_i = 32'h18;  bus.mem_d_wr_i = 4'hF;
    bus.mem_d_data_wr_i = 32'hFFFF_FFFF;  bus.mem_d_req_tag_i = 11'h3FF;
    rst_n = 1'b1;
    wait_init(10, n, bad);
    chk("init_cycles", 64'(n), 64'd32);
    chk("init_accept_low", 64'(bad), 64'd0);
    chk("run_accept", 64'({bus.mem_i_accept_o, bus.mem_d_accept_o}), 64'd3);

    set_data(32'h18, 32'h0, 1'b1, 4'h0, 11'h001, 32'h0, 1'b0);                 tick();
    set_data(32'h0C, 32'hDEADBEEF, 1'b0, 4'hF, 11'h002, 32'h0, 1'b0);          tick();
    set_data(32'h0C, 32'h0, 1'b1, 4'h0, 11'h055, 32'hDEADBEEF, 1'b0);          tick();
    set_data(32'h04, 32'h11223344, 1'b0, 4'hF, 11'h003, 32'h0, 1'b0);          tick();
    set_data(32'h04, 32'h0000AB00, 1'b0, 4'b0010, 11'h004, 32'h0, 1'b0);       tick();
    set_data(32'h04, 32'h0, 1'b1, 4'h0, 11'h005, 32'h1122AB44, 1'b0);          tick();
    set_data(32'h08, 32'h01234567, 1'b0, 4'hF, 11'h006, 32'h0, 1'b0);          tick();
    // Full-lane collision on the upper half, then a plain fetch of the same word.
    set_fetch(32'h08, {32'hCAFEF00D, 32'h01234567}, 1'b0);
    set_data(32'h0C, 32'hCAFEF00D, 1'b0, 4'hF, 11'h007, 32'h0, 1'b0);          tick();
    set_fetch(32'h08, {32'hCAFEF00D, 32'h01234567}, 1'b0);                     tick();
    // Single-byte collision on the lower half.
    set_fetch(32'h08, {32'hCAFEF00D, 32'h012345AA}, 1'b0);
    set_data(32'h08, 32'h000000AA, 1'b0, 4'b0001, 11'h008, 32'h0, 1'b0);       tick();
    // Back-to-back fetches.
    set_fetch(32'h00, {32'h1122AB44, 32'h0}, 1'b0);                            tick();
    set_fetch(32'h08, {32'hCAFEF00D, 32'h012345AA}, 1'b0);                     tick();
    // Out-of-range accesses.
    set_data(32'h100, 32'h0, 1'b1, 4'h0, 11'h009, 32'h0, 1'b1);                tick();
    set_data(32'h10C, 32'hFFFFFFFF, 1'b0, 4'hF, 11'h00A, 32'h0, 1'b1);         tick();
    set_data(32'h0C, 32'h0, 1'b1, 4'h0, 11'h00B, 32'hCAFEF00D, 1'b0);          tick();
    set_fetch(32'h200, 64'h0, 1'b1);                                           tick();
    // Cache op is acked with no data.
    set_data(32'h0C, 32'h0, 1'b0, 4'h0, 11'h00C, 32'h0, 1'b0);
    bus.mem_d_flush_i = 1'b1;                                                  tick();
    // rd together with wr behaves as a write.
    set_data(32'h10, 32'h5A5A5A5A, 1'b1, 4'hF, 11'h00D, 32'h0, 1'b0);          tick();
    set_data(32'h10, 32'h0, 1'b1, 4'h0, 11'h00E, 32'h5A5A5A5A, 1'b0);          tick();
    // Seed words that the refill must clear.
    set_data(32'h18, 32'h77777777, 1'b0, 4'hF, 11'h00F, 32'h0, 1'b0);          tick();
    set_data(32'h80, 32'h88888888, 1'b0, 4'hF, 11'h010, 32'h0, 1'b0);          tick();
    drain();

    // Asynchronous reset from ST_RUN, then a second reset in the middle of the fill.
    rst_n = 1'b0;
    #1;
    chk("async_rst_init_done", 64'(init_done), 64'd0);
    chk("async_rst_accept", 64'({bus.mem_i_accept_o, bus.mem_d_accept_o}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midinit_rst_outputs", 64'({init_done, bus.mem_d_ack_o, bus.mem_i_valid_o}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(0, n, bad);
    chk("refill_cycles", 64'(n), 64'd32);
    chk("refill_accept_low", 64'(bad), 64'd0);

    set_data(32'h18, 32'h0, 1'b1, 4'h0, 11'h011, 32'h0, 1'b0);                 tick();
    set_data(32'h80, 32'h0, 1'b1, 4'h0, 11'h012, 32'h0, 1'b0);                 tick();
    set_data(32'h0C, 32'h0, 1'b1, 4'h0, 11'h013, 32'h0, 1'b0);                 tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
